// File: rtl/fir_bank_scheduler_if.sv
// Stream interface between the sample source, the FIR bank scheduler and the
// downstream decimator/DAC logic. The scheduler takes the slave view: it sinks
// the input sample stream and sources the tagged output sample stream.
interface fir_bank_scheduler_if;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] s_data;
    logic        m_valid;
    logic        m_ready;
    logic [15:0] m_data;
    logic [2:0]  m_chan;
    logic        m_last;

    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data, m_chan, m_last
    );

    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data, m_chan, m_last
    );
endinterface

// File: rtl/fir_bank_scheduler.sv
// Sequencer for the 8-channel FIR bank: accepts one sample, fires the bank,
// waits out the bank latency, snapshots all channel outputs and serialises the
// enabled channels onto the output stream.
// Optional build macro FIR_SCHED_STATS_EN adds frame_count/stall_count outputs.
//
// state   | meaning
// IDLE    | waiting for a sample; ready once the period timer has expired
// FIRE    | din_enable pulse to the bank, load latency counter
// WAIT    | counting down the bank latency
// CAPTURE | snapshot all 8 bank outputs, pick the first enabled channel
// DRAIN   | emit enabled channels in ascending order, one per handshake
module fir_bank_scheduler #(
    parameter int FB_LATENCY = 72,
    parameter int MIN_PERIOD = 80
) (
    input  logic                 clock,
    input  logic                 reset,
    fir_bank_scheduler_if.slave  bus,
    input  logic [7:0]           ch_mask,
    output logic [15:0]          fb_datain,
    output logic                 fb_din_enable,
    input  logic [127:0]         fb_dout,
`ifdef FIR_SCHED_STATS_EN
    output logic [15:0]          frame_count,
    output logic [15:0]          stall_count,
`endif
    output logic                 busy
);
    localparam int TW = $clog2(MIN_PERIOD + 1);
    localparam int WW = $clog2(FB_LATENCY + 1);

    typedef enum logic [2:0] {IDLE, FIRE, WAIT, CAPTURE, DRAIN} state_t;

    state_t        state;
    logic [TW-1:0] timer;
    logic [WW-1:0] wait_cnt;
    logic [7:0]    mask_q;
    logic [2:0]    ch;
    logic [15:0]   snap [8];
    logic          s_ready_i;
    logic          accept;
    logic [2:0]    first_idx;
    logic [2:0]    next_idx;
    logic          first_last;
    logic          next_last;

    // Lowest set bit of mask at or above start; result is don't-care when none.
    function automatic logic [2:0] lowest_from(input logic [7:0] mask, input logic [3:0] start);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (mask[i] && (i >= int'(start))) idx = 3'(i);
        end
        return idx;
    endfunction

    // True when no set bit of mask lies above channel c.
    function automatic logic none_above(input logic [7:0] mask, input logic [2:0] c);
        logic none;
        none = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (mask[i] && (i > int'(c))) none = 1'b0;
        end
        return none;
    endfunction

    assign s_ready_i   = (state == IDLE) && (timer >= TW'(MIN_PERIOD));
    assign accept      = s_ready_i && bus.s_valid;
    assign bus.s_ready = s_ready_i;
    assign busy        = (state != IDLE);

    // Channel selection for the first beat of a frame and for the beat after ch.
    always_comb begin
        first_idx  = lowest_from(mask_q, 4'd0);
        next_idx   = lowest_from(mask_q, {1'b0, ch} + 4'd1);
        first_last = none_above(mask_q, first_idx);
        next_last  = none_above(mask_q, next_idx);
    end

    // Period timer; the accept cycle counts as the first elapsed cycle so that
    // back-to-back acceptances land exactly MIN_PERIOD cycles apart.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            timer <= TW'(MIN_PERIOD);
        end else if (accept) begin
            timer <= TW'(1);
        end else if (timer < TW'(MIN_PERIOD)) begin
            timer <= timer + 1'b1;
        end
    end

    // Main sequencer with registered bank and output-stream signals.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            fb_datain     <= '0;
            fb_din_enable <= 1'b0;
            wait_cnt      <= '0;
            mask_q        <= '0;
            ch            <= '0;
            bus.m_valid   <= 1'b0;
            bus.m_data    <= '0;
            bus.m_chan    <= '0;
            bus.m_last    <= 1'b0;
            for (int k = 0; k < 8; k++) snap[k] <= '0;
        end else begin
            fb_din_enable <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        fb_datain     <= bus.s_data;
                        mask_q        <= ch_mask;
                        fb_din_enable <= 1'b1;
                        state         <= FIRE;
                    end
                end
                FIRE: begin
                    wait_cnt <= WW'(FB_LATENCY - 1);
                    state    <= WAIT;
                end
                WAIT: begin
                    // Leave as the count reaches zero so the capture cycle is
                    // exactly FB_LATENCY cycles after the din_enable pulse.
                    if (wait_cnt <= WW'(1)) begin
                        wait_cnt <= '0;
                        state    <= CAPTURE;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                CAPTURE: begin
                    for (int k = 0; k < 8; k++) snap[k] <= fb_dout[16*k +: 16];
                    if (mask_q == 8'd0) begin
                        state <= IDLE;
                    end else begin
                        ch          <= first_idx;
                        bus.m_valid <= 1'b1;
                        bus.m_data  <= fb_dout[{first_idx, 4'b0000} +: 16];
                        bus.m_chan  <= first_idx;
                        bus.m_last  <= first_last;
                        state       <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (bus.m_ready) begin
                        if (bus.m_last) begin
                            bus.m_valid <= 1'b0;
                            state       <= IDLE;
                        end else begin
                            ch         <= next_idx;
                            bus.m_data <= snap[next_idx];
                            bus.m_chan <= next_idx;
                            bus.m_last <= next_last;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FIR_SCHED_STATS_EN
    // Frame and output-stall statistics, free-running with natural wrap.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            frame_count <= '0;
            stall_count <= '0;
        end else begin
            if (state == FIRE) frame_count <= frame_count + 16'd1;
            if (state == DRAIN && bus.m_valid && !bus.m_ready) stall_count <= stall_count + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_fir_bank_scheduler.sv
// Self-checking bench for fir_bank_scheduler: directed scenarios followed by
// randomized traffic, compared against a transaction-level reference model.
module tb_fir_bank_scheduler;
    localparam int FB_LATENCY = 72;
    localparam int MIN_PERIOD = 80;

    typedef struct {
        logic [15:0] data;
        logic [2:0]  chan;
        logic        last;
    } beat_t;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic [7:0]   ch_mask;
    logic [15:0]  fb_datain;
    logic         fb_din_enable;
    logic [127:0] fb_dout;
    logic         busy;
`ifdef FIR_SCHED_STATS_EN
    logic [15:0]  frame_count;
    logic [15:0]  stall_count;
`endif

    fir_bank_scheduler_if bus();

    fir_bank_scheduler #(.FB_LATENCY(FB_LATENCY), .MIN_PERIOD(MIN_PERIOD)) dut (
        .clock         (clock),
        .reset         (reset),
        .bus           (bus),
        .ch_mask       (ch_mask),
        .fb_datain     (fb_datain),
        .fb_din_enable (fb_din_enable),
        .fb_dout       (fb_dout),
`ifdef FIR_SCHED_STATS_EN
        .frame_count   (frame_count),
        .stall_count   (stall_count),
`endif
        .busy          (busy)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Bank model: new frame visible FB_LATENCY cycles after the pulse, junk before.
    logic [15:0] frame_next [8];
    logic [15:0] frame_live [8];
    int          pend;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            pend <= 0;
        end else if (fb_din_enable) begin
            pend <= 1;
            for (int k = 0; k < 8; k++) frame_live[k] <= frame_next[k];
        end else if (pend != 0 && pend < FB_LATENCY) begin
            pend <= pend + 1;
        end
    end

    always_comb begin
        fb_dout = '0;
        for (int k = 0; k < 8; k++)
            fb_dout[16*k +: 16] = (pend >= FB_LATENCY) ? frame_live[k] : (16'hBAD0 | 16'(k));
    end

    // Reference model state: when the last sample was accepted, whether a frame
    // is still in flight, and the beats that frame must produce.
    int          last_acc;
    bit          outstanding;
    logic [7:0]  acc_mask;
    logic [15:0] datain_exp;
    bit          directed;
    beat_t       exp_q [$];

    task automatic model_reset();
        last_acc    = -100000;
        outstanding = 1'b0;
        acc_mask    = 8'd0;
        datain_exp  = 16'd0;
        exp_q.delete();
    endtask

    // One clock cycle: drive inputs, compare all outputs to the model, advance the model.
    task automatic cycle(input logic sv, input logic [15:0] sd, input logic [7:0] mk, input logic mr);
        bit    exp_ready;
        bit    exp_pulse;
        bit    exp_mv;
        int    hi;
        beat_t b;
        @(negedge clock);
        bus.s_valid = sv;
        bus.s_data  = sd;
        ch_mask     = mk;
        bus.m_ready = mr;
        #1;
        exp_ready = !outstanding && (cyc - last_acc >= MIN_PERIOD);
        exp_pulse = (cyc == last_acc + 1);
        exp_mv    = outstanding && (acc_mask != 8'd0) && (cyc >= last_acc + FB_LATENCY + 2);
        check("s_ready", bus.s_ready, exp_ready);
        check("din_enable", fb_din_enable, exp_pulse);
        check("datain", fb_datain, datain_exp);
        check("busy", busy, outstanding);
        check("m_valid", bus.m_valid, exp_mv);
        if (exp_mv && exp_q.size() > 0) begin
            b = exp_q[0];
            check("m_data", bus.m_data, b.data);
            check("m_chan", bus.m_chan, b.chan);
            check("m_last", bus.m_last, b.last);
            if (mr) begin
                void'(exp_q.pop_front());
                if (b.last) outstanding = 1'b0;
            end
        end
        if (outstanding && acc_mask == 8'd0 && cyc == last_acc + FB_LATENCY + 1)
            outstanding = 1'b0;
        if (sv && exp_ready) begin
            last_acc    = cyc;
            outstanding = 1'b1;
            acc_mask    = mk;
            datain_exp  = sd;
            hi = -1;
            for (int k = 0; k < 8; k++) if (mk[k]) hi = k;
            for (int k = 0; k < 8; k++) begin
                frame_next[k] = directed ? (16'h0100 + 16'(k)) : 16'($urandom);
                if (mk[k]) begin
                    b.data = frame_next[k];
                    b.chan = 3'(k);
                    b.last = (k == hi);
                    exp_q.push_back(b);
                end
            end
        end
        cyc++;
    endtask

    initial begin
        int guard;
        bus.s_valid = 1'b0;
        bus.s_data  = 16'd0;
        bus.m_ready = 1'b0;
        ch_mask     = 8'd0;
        directed    = 1'b1;
        for (int k = 0; k < 8; k++) frame_next[k] = 16'd0;
        model_reset();

        repeat (3) @(negedge clock);
        check("rst_busy", busy, 0);
        check("rst_m_valid", bus.m_valid, 0);
        check("rst_din_enable", fb_din_enable, 0);
        check("rst_datain", fb_datain, 0);
        check("rst_m_data", bus.m_data, 0);
        check("rst_m_chan", bus.m_chan, 0);
        check("rst_m_last", bus.m_last, 0);
        check("rst_s_ready", bus.s_ready, 1);
        reset = 1'b1;

        // Full mask, known bank data, free-flowing output.
        cycle(1'b1, 16'h1234, 8'hFF, 1'b1);
        repeat (99) cycle(1'b0, 16'($urandom), 8'($urandom), 1'b1);
        directed = 1'b0;

        // Sparse mask with toggling backpressure.
        cycle(1'b1, 16'($urandom), 8'b1010_0100, 1'b0);
        repeat (139) cycle(1'b0, 16'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));

        // Empty frame.
        cycle(1'b1, 16'($urandom), 8'h00, 1'b1);
        repeat (99) cycle(1'b0, 16'($urandom), 8'($urandom), 1'b1);

        // s_valid held continuously with a mask short enough to drain within the period.
        repeat (400) cycle(1'b1, 16'($urandom), 8'h3C, 1'b1);

        // Randomized traffic.
        repeat (2500)
            cycle(1'($urandom_range(0, 3) != 0), 16'($urandom),
                  ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom),
                  1'($urandom_range(0, 3) != 0));

        // Reset in the middle of WAIT.
        guard = 0;
        while ((outstanding || (cyc - last_acc < MIN_PERIOD)) && guard < 400) begin
            cycle(1'b0, 16'd0, 8'h00, 1'b1);
            guard++;
        end
        check("drain_timeout", guard < 400, 1);
        cycle(1'b1, 16'h5A5A, 8'hFF, 1'b1);
        repeat (30) cycle(1'b0, 16'd0, 8'hFF, 1'b1);
        @(negedge clock);
        #2 reset = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_m_valid", bus.m_valid, 0);
        check("midrst_din_enable", fb_din_enable, 0);
        check("midrst_datain", fb_datain, 0);
        check("midrst_s_ready", bus.s_ready, 1);
        model_reset();
        @(negedge clock);
        reset = 1'b1;
        repeat (120) cycle(1'b0, 16'($urandom), 8'($urandom), 1'b1);
        cycle(1'b1, 16'h7777, 8'h81, 1'b1);
        repeat (100) cycle(1'b0, 16'($urandom), 8'($urandom), 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
